ans_ltf_ctrl: RTL
=================

# ans_ltf_ctrl

Sequencing controller for the ANS HT-LTF generator (`ans_ht_ltf_gen`) in the openofdm_tx path. It accepts per-packet 128-bit obfuscation coefficient sets over a valid/ready handshake and holds them stable on the generator's `obf_coeff`. It pulses the generator's `boot` and times the IFFT/buffering run. It then plays the 64-sample time-domain LTF, optionally with a 16-sample cyclic prefix, as a registered sample stream to the TX mixer on request. It keeps the generator buffer from being overwritten while a playback is reading it.

## Interface
- GEN_CYCLES, 256: cycles from the `boot` pulse until the generator buffer is complete. Must be at least the generator's worst-case LOADING + IFFT + BUFFERING time.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coeff_valid  in  1  coefficient set offered
- coeff_data  in  128  2 bits per subcarrier; subcarrier k uses bits [2k+1:2k]
- coeff_ready  out  1  controller accepts `coeff_data` this cycle
- gen_boot  out  1  one-cycle start pulse to the generator `boot` input
- gen_coeff  out  128  registered coefficients to the generator `obf_coeff` input
- gen_addr  out  7  read address to the generator `addr` input
- gen_data  in  32  generator sample at `gen_addr`, combinational read
- play_req  in  1  TX requests LTF playback (level; sampled in READY only)
- ltf_valid  out  1  buffer holds a complete LTF for the current `gen_coeff`
- busy  out  1  state is BOOT, GEN or PLAY
- sample_o  out  32  {I[31:16], Q[15:0]} registered sample
- sample_valid  out  1  `sample_o` valid
- play_done  out  1  one-cycle pulse, coincident with the last `sample_valid`

## Operation
- States:
  - IDLE: no valid LTF.
  - BOOT: 1 cycle; `gen_boot`=1.
  - GEN: counting.
  - READY: LTF valid, buffer idle.
  - PLAY: streaming.
- `coeff_ready` = 1 in IDLE, and in READY when `play_req`=0. It is 0 in all other states.
- Handshake (`coeff_valid`&`coeff_ready`):
  - latch `coeff_data` into `gen_coeff`;
  - clear `ltf_valid`;
  - go to BOOT.
- `gen_coeff` changes only on an accepted handshake.
- BOOT → GEN. The 9-bit counter loads GEN_CYCLES-1 and decrements each GEN cycle. At 0 → READY and `ltf_valid`=1.
- READY with `play_req`=1 → PLAY. Play has priority over a simultaneous `coeff_valid`: `coeff_ready` is 0 in that cycle and the offer is held off.
- PLAY: the index k counts 0..N-1.
  - With CP: N=80. `gen_addr` = 48+k for k<16, else k-16.
  - Without CP: N=64, `gen_addr` = k.
  - `sample_o` <= `gen_data` one cycle after `gen_addr` is driven.
  - After k=N-1 → READY.
- `play_req` in any state other than READY is ignored. TX must hold it until `sample_valid` is seen.
- `gen_addr` is 0 outside PLAY.
- Reset values: state IDLE; `gen_coeff`=0, `gen_boot`=0, `gen_addr`=0, `ltf_valid`=0, `busy`=0, `sample_o`=0, `sample_valid`=0, `play_done`=0, `coeff_ready`=0 during the reset cycle.
- Reset mid-GEN or mid-PLAY aborts immediately and leaves no partial stream. The generator shares the same reset.

## Timing
- Handshake at cycle T:
  - `gen_boot`=1 at T+1 only;
  - GEN spans T+2..T+1+GEN_CYCLES;
  - READY and `ltf_valid`=1 from T+2+GEN_CYCLES.
- `play_req` sampled high in READY at cycle P:
  - PLAY from P+1, with `gen_addr`=first address at P+1;
  - first `sample_valid` at P+2;
  - last `sample_valid` and `play_done` at P+1+N;
  - READY at P+1+N.
- `sample_valid` is contiguous for exactly N cycles with no gaps.
- Back-to-back play: if `play_req` is still high at P+1+N (READY), the next PLAY starts at P+2+N. This gives a 1-cycle gap in `sample_valid`.
- Latency from `coeff_valid` to the first playable cycle: GEN_CYCLES+2.

## Configuration
- ANS_LTF_CP_EN defined: N=80. A 16-sample cyclic prefix (addresses 48..63) precedes the 64-sample body.
- ANS_LTF_CP_EN undefined: N=64, body only. The address mux and the CP compare logic are not built.

## Test plan
- After reset, `coeff_valid`=1 with `coeff_data`=0 at cycle T:
  - `coeff_ready`=1 at T;
  - `gen_boot` high only at T+1;
  - `ltf_valid` rises at T+258 (GEN_CYCLES=256);
  - `busy`=1 over T+1..T+257.
- READY, `play_req` raised at P, ANS_LTF_CP_EN defined, generator stub returns data=addr:
  - `sample_o` sequence 48..63 then 0..63;
  - `sample_valid` over P+2..P+81;
  - `play_done` at P+81 only.
- Same stimulus with ANS_LTF_CP_EN undefined:
  - `sample_o` sequence 0..63;
  - `play_done` at P+65.
- READY with `play_req`=1 and `coeff_valid`=1 in the same cycle:
  - PLAY is entered and `coeff_ready`=0 throughout;
  - the handshake completes in the first READY cycle after `play_done` if `play_req` has dropped;
  - `gen_coeff` is unchanged during PLAY.
- `coeff_valid` pulsed during GEN: `coeff_ready`=0, no second `gen_boot`, and `gen_coeff` holds its first value.
- `reset` asserted at PLAY index k=10:
  - next cycle: IDLE, `sample_valid`=0, `ltf_valid`=0, `gen_addr`=0;
  - a following `play_req` is ignored until a new coefficient set completes GEN.

Source files
------------

// File: rtl/ans_ltf_ctrl.sv
// Sequencer for the ANS HT-LTF generator: coefficient intake, boot/IFFT timing, LTF playback.
// Build option: define ANS_LTF_CP_EN to prepend the 16-sample cyclic prefix (80 samples per play).
module ans_ltf_ctrl #(
    parameter int GEN_CYCLES = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         coeff_valid,
    input  logic [127:0] coeff_data,
    output logic         coeff_ready,
    output logic         gen_boot,
    output logic [127:0] gen_coeff,
    output logic [6:0]   gen_addr,
    input  logic [31:0]  gen_data,
    input  logic         play_req,
    output logic         ltf_valid,
    output logic         busy,
    output logic [31:0]  sample_o,
    output logic         sample_valid,
    output logic         play_done
);

`ifdef ANS_LTF_CP_EN
    localparam int N = 80;
`else
    localparam int N = 64;
`endif
    localparam logic [6:0] LAST_IDX = 7'(N - 1);
    localparam logic [8:0] GEN_LOAD = 9'(GEN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_GEN,
        S_READY,
        S_PLAY
    } state_t;

    state_t     state;
    logic [8:0] gen_cnt;
    logic [6:0] idx;
    logic       hs;

    // Playback index to buffer address; the prefix replays the tail of the symbol.
    function automatic logic [6:0] play_addr(input logic [6:0] k);
`ifdef ANS_LTF_CP_EN
        return (k < 7'd16) ? (k + 7'd48) : (k - 7'd16);
`else
        return k;
`endif
    endfunction

    // A pending play request wins over a coefficient offer in READY.
    assign coeff_ready = !reset &&
                         ((state == S_IDLE) || ((state == S_READY) && !play_req));
    assign hs = coeff_valid && coeff_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            gen_cnt      <= '0;
            idx          <= '0;
            gen_coeff    <= '0;
            gen_boot     <= 1'b0;
            gen_addr     <= '0;
            ltf_valid    <= 1'b0;
            busy         <= 1'b0;
            sample_o     <= '0;
            sample_valid <= 1'b0;
            play_done    <= 1'b0;
        end else begin
            gen_boot     <= 1'b0;
            play_done    <= 1'b0;
            sample_valid <= (state == S_PLAY);
            if (state == S_PLAY)
                sample_o <= gen_data;

            case (state)
                S_IDLE: begin
                    if (hs) begin
                        gen_coeff <= coeff_data;
                        ltf_valid <= 1'b0;
                        gen_boot  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_BOOT;
                    end
                end
                S_BOOT: begin
                    gen_cnt <= GEN_LOAD;
                    state   <= S_GEN;
                end
                S_GEN: begin
                    if (gen_cnt == 9'd0) begin
                        ltf_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_READY;
                    end else begin
                        gen_cnt <= gen_cnt - 9'd1;
                    end
                end
                S_READY: begin
                    if (play_req) begin
                        idx      <= '0;
                        gen_addr <= play_addr(7'd0);
                        busy     <= 1'b1;
                        state    <= S_PLAY;
                    end else if (hs) begin
                        gen_coeff <= coeff_data;
                        ltf_valid <= 1'b0;
                        gen_boot  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_BOOT;
                    end
                end
                S_PLAY: begin
                    if (idx == LAST_IDX) begin
                        gen_addr  <= '0;
                        busy      <= 1'b0;
                        play_done <= 1'b1;
                        state     <= S_READY;
                    end else begin
                        idx      <= idx + 7'd1;
                        gen_addr <= play_addr(idx + 7'd1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
